reaction_referee: RTL and testbench
===================================

REACTION_REFEREE -- requirements
Module: reaction_referee

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 5; it is the score at which a player wins the game.
REQ-002 The block SHALL have parameter TIMEOUT_MS, default 1000; it is the number of tick_1ms pulses allowed after go before the round is void.
REQ-003 Port clk SHALL be an input, 1 bit: the system clock.
REQ-004 Port reset SHALL be an input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port tick_1ms SHALL be an input, 1 bit: a single-clk pulse once per millisecond, synchronous to clk.
REQ-006 Port start SHALL be an input, 1 bit: the debounced, active-high start button level.
REQ-007 Port go SHALL be an input, 1 bit: the countdown-expired level from the upstream countdown.
REQ-008 Port sw_p1 SHALL be an input, 1 bit: the raw player-1 switch (SW0), asynchronous.
REQ-009 Port sw_p2 SHALL be an input, 1 bit: the raw player-2 switch (SW9), asynchronous.
REQ-010 Port p1_score SHALL be an output, 3 bits: the player-1 score.
REQ-011 Port p2_score SHALL be an output, 3 bits: the player-2 score.
REQ-012 Port winner SHALL be an output, 2 bits: 00 none, 01 P1, 10 P2.
REQ-013 Port game_over SHALL be an output, 1 bit: high while in state GAME_OVER.
REQ-014 Port round_active SHALL be an output, 1 bit: high in WAIT_GO or WAIT_FLIP.
REQ-015 Port p1_punish SHALL be an output, 1 bit: a one-clk pulse for a player-1 false start.
REQ-016 Port p2_punish SHALL be an output, 1 bit: a one-clk pulse for a player-2 false start.
REQ-017 Port react_ms SHALL be an output, 10 bits: the reaction time of the last scoring flip, in ms.

Function
REQ-018 sw_p1, sw_p2 and go SHALL each pass through a 2-flop synchronizer; rising-edge detection SHALL use the synchronized values.
REQ-019 start SHALL be rising-edge detected; the held level SHALL be ignored.
REQ-020 The FSM SHALL have states IDLE, WAIT_GO, WAIT_FLIP, SETTLE and GAME_OVER.
REQ-021 IDLE -> WAIT_GO SHALL occur on a start edge while both synchronized switches are low; a start edge with a switch high SHALL be ignored.
REQ-022 In WAIT_GO, a switch rising edge SHALL be a false start: if that player's score > 0 it SHALL decrement by 1, otherwise it SHALL stay at 0; the punish pulse SHALL fire regardless of score; next state SHALL be SETTLE.
REQ-023 Both switches rising in the same clk in WAIT_GO SHALL punish both players under the same rule.
REQ-024 WAIT_GO -> WAIT_FLIP SHALL occur when synchronized go is high.
REQ-025 A switch edge in the same clk as go rising SHALL count as valid, not false.
REQ-026 In WAIT_FLIP, an rt counter SHALL clear on entry and increment on each tick_1ms, saturating at 1023.
REQ-027 The first single-player switch edge in WAIT_FLIP SHALL add +1 to that player's score and SHALL load react_ms from rt.
REQ-028 Simultaneous edges from both players in WAIT_FLIP SHALL be a tie: no score change, react_ms unchanged, next state SETTLE.
REQ-029 When rt reaches TIMEOUT_MS in WAIT_FLIP: no score change, next state SETTLE.
REQ-030 Every score change SHALL be visible on the clk edge that leaves the deciding state, i.e. 3 clk after the switch pin changes.
REQ-031 SETTLE SHALL wait until both synchronized switches are low, then go to GAME_OVER if either score == WIN_SCORE, else IDLE.
REQ-032 Scores SHALL never exceed WIN_SCORE and SHALL never wrap below 0.
REQ-033 On entry to GAME_OVER, winner SHALL be set to the player holding WIN_SCORE.
REQ-034 A start edge in GAME_OVER SHALL clear both scores, winner and react_ms, and go to IDLE.
REQ-035 All other inputs in GAME_OVER SHALL be ignored.

Reset
REQ-036 Reset SHALL force state IDLE and clear all outputs, synchronizer flops, edge-detect history and rt to 0.
REQ-037 Reset mid-round SHALL discard the round with no score update.
REQ-038 On the first clk after reset release, a switch that is already high SHALL NOT be treated as an edge.

Structure
REQ-039 A shared package SHALL hold the state enum, the winner encodings (NONE/P1/P2) and the score width (3 bits).
REQ-040 The block SHALL use one sub-module, sync_edge (2-flop synchronizer plus rising-edge pulse), instantiated three times: sw_p1, sw_p2 and go.

Verification
REQ-041 Start edge, go high after 50 ms, sw_p1 rises 120 ms after go -> p1_score=1, react_ms=120, state SETTLE until both switches low, then IDLE.
REQ-042 sw_p2 rises during WAIT_GO with p2_score=2 -> p2_punish pulse, p2_score=1; repeat at p2_score=0 -> pulse, score stays 0.
REQ-043 Both switches rise in the same clk in WAIT_FLIP -> scores unchanged, react_ms unchanged, next state SETTLE.
REQ-044 No flip for 1000 ticks after go -> SETTLE then IDLE, no score change, round_active low.
REQ-045 p1 wins 5 rounds -> game_over=1, winner=01; later switch edges are ignored; a start edge clears scores and winner.
REQ-046 Assert reset during WAIT_FLIP with p1_score=3 -> all outputs 0 and state IDLE; a switch held high through reset release gives no score.

Source files
------------

// File: rtl/reaction_referee_pkg.sv
// Shared types and helpers for the reaction-game referee.
package reaction_referee_pkg;

  localparam int SCORE_W = 3;
  localparam int RT_W    = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_GO   = 3'd1,
    WAIT_FLIP = 3'd2,
    SETTLE    = 3'd3,
    GAME_OVER = 3'd4
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Add one point, never passing the winning score.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] lim);
    if (s >= lim) begin
      return lim;
    end else begin
      return s + SCORE_W'(1);
    end
  endfunction

  // Take one point away, never wrapping below zero.
  function automatic logic [SCORE_W-1:0] score_dec(input logic [SCORE_W-1:0] s);
    if (s == SCORE_W'(0)) begin
      return SCORE_W'(0);
    end else begin
      return s - SCORE_W'(1);
    end
  endfunction

endpackage

// File: rtl/reaction_referee_sync_edge.sv
// Two-flop synchronizer with a rising-edge pulse. Edge reporting stays
// disarmed until the chain has refilled after reset, so an input that is
// already high at reset release never looks like a fresh edge.
module sync_edge
  import reaction_referee_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [1:0] arm_q;

  // Synchronizer chain, edge history and post-reset arming counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      arm_q  <= 2'd0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (arm_q != 2'd3) begin
        arm_q <= arm_q + 2'd1;
      end else begin
        arm_q <= arm_q;
      end
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q & (arm_q == 2'd3);

endmodule

// File: rtl/reaction_referee.sv
// Referee for a two-player reaction game: arms a round on start, punishes
// false starts, scores the first flip after go, and declares a winner.
module reaction_referee
  import reaction_referee_pkg::*;
#(
  parameter int WIN_SCORE  = 5,
  parameter int TIMEOUT_MS = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1ms,
  input  logic               start,
  input  logic               go,
  input  logic               sw_p1,
  input  logic               sw_p2,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic               game_over,
  output logic               round_active,
  output logic               p1_punish,
  output logic               p2_punish,
  output logic [RT_W-1:0]    react_ms
);

  localparam logic [SCORE_W-1:0] WIN_C     = SCORE_W'(WIN_SCORE);
  localparam logic [RT_W-1:0]    TIMEOUT_C = RT_W'(TIMEOUT_MS);
  localparam logic [RT_W-1:0]    RT_MAX    = {RT_W{1'b1}};

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         winner_q, winner_d;
  logic [RT_W-1:0]    rt_q, rt_d, react_q, react_d;
  logic               game_over_q, game_over_d;
  logic               active_q, active_d;
  logic               pun1_q, pun1_d, pun2_q, pun2_d;
  logic               start_q;

  logic sw1_s, sw1_rise_s, sw2_s, sw2_rise_s, go_s, go_rise_s;
  logic start_rise_s, go_open_s, any_rise_s, one_rise_s;

  sync_edge u_sync_p1 (.clk(clk), .reset(reset), .async_i(sw_p1), .sync_o(sw1_s), .rise_o(sw1_rise_s));
  sync_edge u_sync_p2 (.clk(clk), .reset(reset), .async_i(sw_p2), .sync_o(sw2_s), .rise_o(sw2_rise_s));
  sync_edge u_sync_go (.clk(clk), .reset(reset), .async_i(go),    .sync_o(go_s),  .rise_o(go_rise_s));

  assign start_rise_s = start & ~start_q;
  // A go that is just rising already opens the flip window, so a switch
  // edge landing in that same clk is a valid reaction.
  assign go_open_s    = go_s | go_rise_s;
  assign any_rise_s   = sw1_rise_s | sw2_rise_s;
  assign one_rise_s   = sw1_rise_s ^ sw2_rise_s;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      p1_q        <= '0;
      p2_q        <= '0;
      winner_q    <= WIN_NONE;
      rt_q        <= '0;
      react_q     <= '0;
      game_over_q <= 1'b0;
      active_q    <= 1'b0;
      pun1_q      <= 1'b0;
      pun2_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      winner_q    <= winner_d;
      rt_q        <= rt_d;
      react_q     <= react_d;
      game_over_q <= game_over_d;
      active_q    <= active_d;
      pun1_q      <= pun1_d;
      pun2_q      <= pun2_d;
      start_q     <= start;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_rise_s && !sw1_s && !sw2_s) state_d = WAIT_GO;
        else                                  state_d = IDLE;
      end
      WAIT_GO: begin
        if (any_rise_s)     state_d = SETTLE;
        else if (go_open_s) state_d = WAIT_FLIP;
        else                state_d = WAIT_GO;
      end
      WAIT_FLIP: begin
        if ((rt_q == TIMEOUT_C) || any_rise_s) state_d = SETTLE;
        else                                   state_d = WAIT_FLIP;
      end
      SETTLE: begin
        if (sw1_s || sw2_s)                        state_d = SETTLE;
        else if ((p1_q == WIN_C) || (p2_q == WIN_C)) state_d = GAME_OVER;
        else                                       state_d = IDLE;
      end
      GAME_OVER: begin
        if (start_rise_s) state_d = IDLE;
        else              state_d = GAME_OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scores, reaction timer, punish pulses and status flags.
  always_comb begin
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    react_d  = react_q;
    rt_d     = '0;
    pun1_d   = 1'b0;
    pun2_d   = 1'b0;
    case (state_q)
      WAIT_GO: begin
        if (go_open_s) begin
          if (one_rise_s) begin
            react_d = rt_q;
            if (sw1_rise_s) p1_d = score_inc(p1_q, WIN_C);
            else            p2_d = score_inc(p2_q, WIN_C);
          end else begin
            react_d = react_q;
          end
        end else begin
          if (sw1_rise_s) begin
            p1_d   = score_dec(p1_q);
            pun1_d = 1'b1;
          end else begin
            pun1_d = 1'b0;
          end
          if (sw2_rise_s) begin
            p2_d   = score_dec(p2_q);
            pun2_d = 1'b1;
          end else begin
            pun2_d = 1'b0;
          end
        end
      end
      WAIT_FLIP: begin
        if (tick_1ms && (rt_q != RT_MAX)) rt_d = rt_q + RT_W'(1);
        else                              rt_d = rt_q;
        if ((rt_q != TIMEOUT_C) && one_rise_s) begin
          react_d = rt_q;
          if (sw1_rise_s) p1_d = score_inc(p1_q, WIN_C);
          else            p2_d = score_inc(p2_q, WIN_C);
        end else begin
          react_d = react_q;
        end
      end
      GAME_OVER: begin
        if (start_rise_s) begin
          p1_d     = '0;
          p2_d     = '0;
          winner_d = WIN_NONE;
          react_d  = '0;
        end else begin
          winner_d = winner_q;
        end
      end
      default: begin
        rt_d = '0;
      end
    endcase
    if ((state_d == GAME_OVER) && (state_q != GAME_OVER)) begin
      winner_d = (p1_q == WIN_C) ? WIN_P1 : WIN_P2;
    end else begin
      winner_d = winner_d;
    end
    game_over_d = (state_d == GAME_OVER);
    active_d    = (state_d == WAIT_GO) || (state_d == WAIT_FLIP);
  end

  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign winner       = winner_q;
  assign game_over    = game_over_q;
  assign round_active = active_q;
  assign p1_punish    = pun1_q;
  assign p2_punish    = pun2_q;
  assign react_ms     = react_q;

endmodule

// File: tb/tb_reaction_referee.sv
// Directed bench for reaction_referee with a scoreboard of expected outputs.
module tb_reaction_referee;

  logic       clk = 1'b0;
  logic       reset, tick_1ms, start, go, sw_p1, sw_p2;
  logic [2:0] p1_score, p2_score;
  logic [1:0] winner;
  logic       game_over, round_active, p1_punish, p2_punish;
  logic [9:0] react_ms;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_p1 = 0, m_p2 = 0, m_react = 0, m_winner = 0;

  always #5 clk = ~clk;

  reaction_referee #(.WIN_SCORE(5), .TIMEOUT_MS(1000)) dut (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start(start), .go(go),
    .sw_p1(sw_p1), .sw_p2(sw_p2), .p1_score(p1_score), .p2_score(p2_score),
    .winner(winner), .game_over(game_over), .round_active(round_active),
    .p1_punish(p1_punish), .p2_punish(p2_punish), .react_ms(react_ms)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1ms = 1'b1; step();
      tick_1ms = 1'b0; step();
    end
  endtask

  task automatic start_pulse();
    start = 1'b1; step();
    start = 1'b0; step();
  endtask

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] actual);
    exp_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got %0d with nothing expected", actual);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      assert (actual === e.val) else begin
        errors++;
        $error("FAIL %s: got %0d expected %0d", e.tag, actual, e.val);
      end
    end
  endtask

  task automatic expect_all(input int go_e, input int ra_e, input int pu1_e, input int pu2_e);
    push("p1_score", m_p1);
    push("p2_score", m_p2);
    push("react_ms", m_react);
    push("winner", m_winner);
    push("game_over", go_e);
    push("round_active", ra_e);
    push("p1_punish", pu1_e);
    push("p2_punish", pu2_e);
  endtask

  task automatic check_all();
    check_pop(32'(p1_score));
    check_pop(32'(p2_score));
    check_pop(32'(react_ms));
    check_pop(32'(winner));
    check_pop(32'(game_over));
    check_pop(32'(round_active));
    check_pop(32'(p1_punish));
    check_pop(32'(p2_punish));
  endtask

  // Full round won by player `who`; ms == 0 flips in the same clk as go.
  task automatic win_round(input int who, input int ms);
    int ge;
    start_pulse();
    push("round_started", 1); check_pop(32'(round_active));
    tick_n(50);
    go = 1'b1;
    if (ms > 0) begin
      repeat (4) step();
      tick_n(ms);
    end
    if (who == 1) begin
      sw_p1 = 1'b1;
      if (m_p1 < 5) m_p1++;
    end else begin
      sw_p2 = 1'b1;
      if (m_p2 < 5) m_p2++;
    end
    m_react = ms;
    expect_all(0, 0, 0, 0);
    repeat (3) step();
    check_all();
    repeat (2) step();
    start_pulse();
    push("settle_holds", 0); check_pop(32'(round_active));
    sw_p1 = 1'b0; sw_p2 = 1'b0; go = 1'b0;
    repeat (4) step();
    if (m_p1 == 5) m_winner = 1;
    else if (m_p2 == 5) m_winner = 2;
    ge = (m_p1 == 5 || m_p2 == 5) ? 1 : 0;
    expect_all(ge, 0, 0, 0);
    check_all();
  endtask

  // False start by player 1, player 2 or both (who == 3) from IDLE.
  task automatic false_start(input int who);
    int p1e, p2e;
    start_pulse();
    push("round_started", 1); check_pop(32'(round_active));
    repeat (5) step();
    p1e = (who == 1 || who == 3) ? 1 : 0;
    p2e = (who == 2 || who == 3) ? 1 : 0;
    if (p1e == 1) begin sw_p1 = 1'b1; if (m_p1 > 0) m_p1--; end
    if (p2e == 1) begin sw_p2 = 1'b1; if (m_p2 > 0) m_p2--; end
    expect_all(0, 0, p1e, p2e);
    repeat (3) step();
    check_all();
    step();
    push("p1_punish_end", 0); check_pop(32'(p1_punish));
    push("p2_punish_end", 0); check_pop(32'(p2_punish));
    sw_p1 = 1'b0; sw_p2 = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    reset = 1'b1; tick_1ms = 1'b0; start = 1'b0; go = 1'b0; sw_p1 = 1'b0; sw_p2 = 1'b0;
    repeat (3) step();
    expect_all(0, 0, 0, 0);
    check_all();
    reset = 1'b0;
    repeat (4) step();

    // Basic scoring round, then false starts and p2 scoring.
    win_round(1, 120);
    false_start(1);
    win_round(2, 30);
    win_round(2, 77);
    false_start(2);
    false_start(2);
    false_start(2);

    // Tie in the flip window.
    start_pulse();
    go = 1'b1;
    repeat (4) step();
    tick_n(10);
    sw_p1 = 1'b1; sw_p2 = 1'b1;
    expect_all(0, 0, 0, 0);
    repeat (3) step();
    check_all();
    sw_p1 = 1'b0; sw_p2 = 1'b0; go = 1'b0;
    repeat (4) step();

    // Timeout with no flip.
    start_pulse();
    go = 1'b1;
    repeat (4) step();
    tick_n(999);
    push("before_timeout", 1); check_pop(32'(round_active));
    tick_n(1);
    expect_all(0, 0, 0, 0);
    check_all();
    go = 1'b0;
    repeat (4) step();

    // Both players false-start in the same clk.
    false_start(3);

    // Player 1 takes five rounds, one flip landing with go itself.
    win_round(1, 0);
    win_round(1, 300);
    win_round(1, 5);
    win_round(1, 450);
    win_round(1, 60);

    // Inputs other than start are ignored once the game is over.
    sw_p2 = 1'b1; go = 1'b1;
    tick_n(3);
    sw_p2 = 1'b0; go = 1'b0;
    repeat (4) step();
    expect_all(1, 0, 0, 0);
    check_all();
    start_pulse();
    m_p1 = 0; m_p2 = 0; m_winner = 0; m_react = 0;
    expect_all(0, 0, 0, 0);
    check_all();

    // Reset in the middle of a round with p1 at 3.
    win_round(1, 10);
    win_round(1, 20);
    win_round(1, 30);
    start_pulse();
    go = 1'b1;
    repeat (4) step();
    tick_n(5);
    sw_p1 = 1'b1; reset = 1'b1; go = 1'b0;
    m_p1 = 0; m_p2 = 0; m_react = 0; m_winner = 0;
    expect_all(0, 0, 0, 0);
    step();
    check_all();
    step();
    reset = 1'b0;
    repeat (6) step();
    expect_all(0, 0, 0, 0);
    check_all();
    start_pulse();
    push("start_with_switch_high", 0); check_pop(32'(round_active));
    sw_p1 = 1'b0;
    repeat (4) step();
    start_pulse();
    push("start_after_release", 1); check_pop(32'(round_active));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
